// File: rtl/fifo_tr_pkg.sv
// Shared definitions for the transpose-FIFO bank and its sequencer:
// the ctl bus encodings and the sequencer state type.
package fifo_tr_pkg;

  localparam int CTL_W = 2;

  localparam logic [CTL_W-1:0] CTL_HOLD  = 2'b00;
  localparam logic [CTL_W-1:0] CTL_LOAD  = 2'b01;
  localparam logic [CTL_W-1:0] CTL_SHIFT = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } tr_state_t;

endpackage

// File: rtl/fifo_tr.sv
// One transpose FIFO: a load captures a whole row behind DELAY zero slots,
// then each shift moves the next element onto dout, back-filling with zeros.
module fifo_tr
  import fifo_tr_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int DELAY = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CTL_W-1:0]           ctl,
  input  logic [DEPTH-1:0][W-1:0]    din,
  output logic [W-1:0]               dout
);

  localparam int L = DEPTH + DELAY;

  logic [L-1:0][W-1:0] mem;
  logic [L-1:0][W-1:0] load_img;
  logic [L-1:0][W-1:0] shift_img;

  // Slot 0 is the output; the DELAY leading slots hold the zero padding.
  for (genvar i = 0; i < L; i++) begin : g_img
    if (i < DELAY) begin : g_pad
      assign load_img[i] = '0;
    end else begin : g_data
      assign load_img[i] = din[i-DELAY];
    end
    if (i == L-1) begin : g_tail
      assign shift_img[i] = '0;
    end else begin : g_next
      assign shift_img[i] = mem[i+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      case (ctl)
        CTL_LOAD:  mem <= load_img;
        CTL_SHIFT: mem <= shift_img;
        default:   mem <= mem;
      endcase
    end
  end

  assign dout = mem[0];

endmodule

// File: rtl/fifo_tr_ctrl.sv
// Sequencer for a bank of transpose FIFOs: takes one tile per handshake,
// drives the shared ctl bus and counts the LEN-cycle skewed drain.
module fifo_tr_ctrl
  import fifo_tr_pkg::*;
#(
  parameter  int DEPTH     = 8,
  parameter  int MAX_DELAY = DEPTH - 1,
  localparam int LEN       = DEPTH + MAX_DELAY,
  localparam int CW        = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [CTL_W-1:0] ctl,
  output logic             out_valid,
  output logic [CW-1:0]    out_idx,
  output logic             out_last,
  output logic             done,
  output logic             busy
);

  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  tr_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The last drain cycle doubles as a load slot so tiles stream without a bubble.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ctl        = CTL_HOLD;
    in_ready   = 1'b0;
    done       = 1'b0;

    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            ctl        = CTL_LOAD;
            state_next = DRAIN;
            cnt_next   = '0;
          end
        end
        DRAIN: begin
          if (!stall) begin
            if (cnt == LAST) begin
              done     = 1'b1;
              in_ready = 1'b1;
              cnt_next = '0;
              if (in_valid) begin
                ctl = CTL_LOAD;
              end else begin
                state_next = IDLE;
              end
            end else begin
              ctl      = CTL_SHIFT;
              cnt_next = cnt + CW'(1);
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    // Reset must silence the handshake and ctl bus before the first clock edge.
    if (rst) begin
      ctl      = CTL_HOLD;
      in_ready = 1'b0;
      done     = 1'b0;
    end
  end

  assign out_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign out_idx   = cnt;
  assign out_last  = out_valid && (cnt == LAST);

endmodule

// File: tb/tb_fifo_tr_ctrl.sv
// Directed bench for fifo_tr_ctrl driving a DEPTH=4 bank of transpose FIFOs
// at DELAY 0..3, checking ctl, drain indices, done and FIFO data per cycle.
module tb_fifo_tr_ctrl;
  import fifo_tr_pkg::*;

  localparam int DEPTH     = 4;
  localparam int MAX_DELAY = 3;
  localparam int LEN       = 7;
  localparam int CW        = 3;
  localparam int W         = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic             in_ready;
  logic [CTL_W-1:0] ctl;
  logic             out_valid;
  logic [CW-1:0]    out_idx;
  logic             out_last;
  logic             done;
  logic             busy;

  logic [DEPTH-1:0][W-1:0] rows [DEPTH];
  logic [W-1:0]            dout [DEPTH];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_tr_ctrl #(.DEPTH(DEPTH), .MAX_DELAY(MAX_DELAY)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .stall     (stall),
    .flush     (flush),
    .ctl       (ctl),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done),
    .busy      (busy)
  );

  for (genvar d = 0; d < DEPTH; d++) begin : g_bank
    fifo_tr #(.W(W), .DEPTH(DEPTH), .DELAY(d)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .ctl  (ctl),
      .din  (rows[d]),
      .dout (dout[d])
    );
  end

  // Row d of a tile holds d*DEPTH+1 .. d*DEPTH+DEPTH, so FIFO 0 yields 1,2,3,4.
  function automatic int exp_data(int d, int i);
    if (i >= d && (i - d) < DEPTH) return d * DEPTH + 1 + (i - d);
    return 0;
  endfunction

  task automatic load_rows();
    for (int d = 0; d < DEPTH; d++)
      for (int e = 0; e < DEPTH; e++)
        rows[d][e] = W'(d * DEPTH + 1 + e);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic apply_stimulus(input logic iv, input logic st, input logic fl);
    @(negedge clk);
    in_valid = iv;
    stall    = st;
    flush    = fl;
    #1;
  endtask

  task automatic check_cycle(input string tag, input int e_ctl, input int e_valid,
                             input int e_idx, input int e_done, input int e_ready);
    check_output({tag, ".ctl"},       32'(ctl),       32'(e_ctl));
    check_output({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
    check_output({tag, ".busy"},      32'(busy),      32'(e_valid));
    check_output({tag, ".done"},      32'(done),      32'(e_done));
    check_output({tag, ".in_ready"},  32'(in_ready),  32'(e_ready));
    check_output({tag, ".out_last"},  32'(out_last),
                 32'((e_valid != 0 && e_idx == LEN - 1) ? 1 : 0));
    if (e_valid != 0)
      check_output({tag, ".out_idx"}, 32'(out_idx), 32'(e_idx));
  endtask

  task automatic check_data(input string tag, input int idx);
    for (int d = 0; d < DEPTH; d++)
      check_output($sformatf("%s.dout%0d", tag, d), 32'(dout[d]), 32'(exp_data(d, idx)));
  endtask

  task automatic run_single_tile(input string tag);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_cycle({tag, ".t0"}, CTL_LOAD, 0, 0, 0, 1);
    for (int k = 1; k <= LEN; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_cycle($sformatf("%s.t%0d", tag, k), (k < LEN) ? CTL_SHIFT : CTL_HOLD,
                  1, k - 1, (k == LEN) ? 1 : 0, (k == LEN) ? 1 : 0);
      check_data($sformatf("%s.t%0d", tag, k), k - 1);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_cycle({tag, ".idle"}, CTL_HOLD, 0, 0, 0, 1);
  endtask

  initial begin
    int idx;
    logic st;

    rst      = 1'b1;
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    load_rows();

    // Reset state, including a pending in_valid that must not leak through.
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    check_cycle("reset", CTL_HOLD, 0, 0, 0, 0);
    check_output("reset.out_idx", 32'(out_idx), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check_cycle("post_reset", CTL_HOLD, 0, 0, 0, 1);

    run_single_tile("single");

    // Two tiles back to back: in_valid held through the second load slot.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_cycle("b2b.t0", CTL_LOAD, 0, 0, 0, 1);
    for (int k = 1; k <= 2 * LEN; k++) begin
      apply_stimulus((k <= LEN) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      check_cycle($sformatf("b2b.t%0d", k),
                  (k == LEN) ? CTL_LOAD : (k == 2 * LEN) ? CTL_HOLD : CTL_SHIFT,
                  1, (k - 1) % LEN, (k % LEN == 0) ? 1 : 0, (k % LEN == 0) ? 1 : 0);
      check_data($sformatf("b2b.t%0d", k), (k - 1) % LEN);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_cycle("b2b.idle", CTL_HOLD, 0, 0, 0, 1);

    // Three stall cycles at out_idx 2 push done from t+7 to t+10.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_cycle("stall.t0", CTL_LOAD, 0, 0, 0, 1);
    idx = 0;
    for (int k = 1; k <= LEN + 3; k++) begin
      st = (k >= 3 && k <= 5);
      apply_stimulus(1'b0, st, 1'b0);
      check_cycle($sformatf("stall.t%0d", k),
                  st ? CTL_HOLD : (idx == LEN - 1) ? CTL_HOLD : CTL_SHIFT,
                  1, idx, (k == LEN + 3) ? 1 : 0, (k == LEN + 3) ? 1 : 0);
      check_data($sformatf("stall.t%0d", k), idx);
      if (!st) idx++;
    end
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_cycle("stall.idle", CTL_HOLD, 0, 0, 0, 1);

    // Stall on the last element with the next tile waiting.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_cycle("slast.t0", CTL_LOAD, 0, 0, 0, 1);
    for (int k = 1; k < LEN; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_cycle($sformatf("slast.t%0d", k), CTL_SHIFT, 1, k - 1, 0, 0);
    end
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0);
      check_cycle($sformatf("slast.hold%0d", k), CTL_HOLD, 1, LEN - 1, 0, 0);
      check_data($sformatf("slast.hold%0d", k), LEN - 1);
    end
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_cycle("slast.release", CTL_LOAD, 1, LEN - 1, 1, 1);

    // Drain the new tile to out_idx 4, then flush with stall also high.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_cycle($sformatf("flush.idx%0d", k), CTL_SHIFT, 1, k, 0, 0);
      check_data($sformatf("flush.idx%0d", k), k);
    end
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_cycle("flush.abort", CTL_HOLD, 1, 4, 0, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_cycle("flush.idle", CTL_HOLD, 0, 0, 0, 1);
    check_output("flush.out_idx", 32'(out_idx), 32'd0);

    run_single_tile("after_flush");

    // Asynchronous reset between clock edges in the middle of a drain.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_cycle("arst.t0", CTL_LOAD, 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_cycle($sformatf("arst.t%0d", k), CTL_SHIFT, 1, k - 1, 0, 0);
    end
    #1;
    in_valid = 1'b1;
    rst      = 1'b1;
    #1;
    check_cycle("arst.assert", CTL_HOLD, 0, 0, 0, 0);
    check_output("arst.out_idx", 32'(out_idx), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check_cycle("arst.release", CTL_HOLD, 0, 0, 0, 1);
    check_output("arst.release.out_idx", 32'(out_idx), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
